tlb_ptw: RTL

Hardware page-table walker for the Sv32 TLB. It sits directly downstream of the TLB controller: it accepts a miss request on the PTW handshake, issues one or two page-table reads to the memory port, validates the PTE, and returns the leaf PTE, its level, and a fault flag to the controller for the TLB refill.

---
 rtl/tlb_ptw.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tlb_ptw.sv
// tlb_ptw: Sv32 hardware page-table walker behind the TLB controller.
// Takes one miss at a time on the ptw_req handshake. It issues one or two
// PTE reads on the mem_req/mem_resp port, then returns the PTE, the leaf
// level and a fault flag on the ptw_resp handshake.
// Ports: clk, rst (sync, active-high), root_ppn_i,
//   ptw_req_{valid_i,ready_o,vpn_i},
//   ptw_resp_{valid_o,ready_i,pte_o,level_o,fault_o},
//   mem_req_{valid_o,ready_i,addr_o},
//   mem_resp_{valid_i,ready_o,data_i}.
// Option: define PTW_AD_CHECK_EN to fault leaf PTEs whose A bit is clear.
module tlb_ptw #(
  parameter int VPN_WIDTH = 20,
  parameter int PPN_WIDTH = 22,
  parameter int PA_WIDTH  = 34,
  parameter int PTE_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PPN_WIDTH-1:0] root_ppn_i,
  input  logic                 ptw_req_valid_i,
  output logic                 ptw_req_ready_o,
  input  logic [VPN_WIDTH-1:0] ptw_req_vpn_i,
  output logic                 ptw_resp_valid_o,
  input  logic                 ptw_resp_ready_i,
  output logic [PTE_WIDTH-1:0] ptw_resp_pte_o,
  output logic                 ptw_resp_level_o,
  output logic                 ptw_resp_fault_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PA_WIDTH-1:0]  mem_req_addr_o,
  input  logic                 mem_resp_valid_i,
  output logic                 mem_resp_ready_o,
  input  logic [PTE_WIDTH-1:0] mem_resp_data_i
);

  localparam int IDX_W = VPN_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
  logic                 req_ready_q, req_ready_d;
  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_resp_ready_q, mem_resp_ready_d;
  logic [PA_WIDTH-1:0]  addr_q, addr_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [PTE_WIDTH-1:0] pte_q, pte_d;
  logic                 level_q, level_d;
  logic                 fault_q, fault_d;

  // PTE byte address: {ppn, 12'b0} + {idx, 2'b00}, kept at full PA width.
  function automatic logic [PA_WIDTH-1:0] pte_addr(
    input logic [PPN_WIDTH-1:0] ppn,
    input logic [IDX_W-1:0]     idx
  );
    logic [PA_WIDTH-1:0] base;
    logic [PA_WIDTH-1:0] offs;
    base = PA_WIDTH'({ppn, 12'b0});
    offs = PA_WIDTH'({idx, 2'b00});
    return base + offs;
  endfunction

  // PTE decode of the incoming read data
  logic                 pte_v, pte_r, pte_w, pte_x, pte_a;
  logic                 pte_bad, pte_leaf, at_l1;
  logic                 sp_misaligned, leaf_fault;
  logic [PPN_WIDTH-1:0] pte_ppn;

  always_comb begin
    pte_v         = mem_resp_data_i[0];
    pte_r         = mem_resp_data_i[1];
    pte_w         = mem_resp_data_i[2];
    pte_x         = mem_resp_data_i[3];
    pte_a         = mem_resp_data_i[6];
    pte_ppn       = PPN_WIDTH'(mem_resp_data_i >> 10);
    pte_bad       = !pte_v || (!pte_r && pte_w);
    pte_leaf      = pte_r || pte_x;
    at_l1         = (state_q == L1_WAIT);
    // A level-1 leaf maps a 4 MiB superpage, so PPN[0] must be zero.
    sp_misaligned = at_l1 && (mem_resp_data_i[19:10] != 10'd0);
`ifdef PTW_AD_CHECK_EN
    leaf_fault    = sp_misaligned || !pte_a;
`else
    leaf_fault    = sp_misaligned;
`endif
  end

  always_comb begin
    state_d          = state_q;
    vpn_d            = vpn_q;
    req_ready_d      = req_ready_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_resp_ready_d = mem_resp_ready_q;
    addr_d           = addr_q;
    resp_valid_d     = resp_valid_q;
    pte_d            = pte_q;
    level_d          = level_q;
    fault_d          = fault_q;

    unique case (state_q)
      IDLE: begin
        if (ptw_req_valid_i && req_ready_q) begin
          vpn_d           = ptw_req_vpn_i;
          addr_d          = pte_addr(root_ppn_i,
                              ptw_req_vpn_i[VPN_WIDTH-1:IDX_W]);
          req_ready_d     = 1'b0;
          mem_req_valid_d = 1'b1;
          state_d         = L1_REQ;
        end
      end
      L1_REQ, L0_REQ: begin
        if (mem_req_ready_i) begin
          mem_req_valid_d  = 1'b0;
          mem_resp_ready_d = 1'b1;
          state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
        end
      end
      L1_WAIT, L0_WAIT: begin
        if (mem_resp_valid_i) begin
          pte_d            = mem_resp_data_i;
          level_d          = at_l1;
          mem_resp_ready_d = 1'b0;
          if (pte_bad) begin
            fault_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (pte_leaf) begin
            fault_d      = leaf_fault;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (at_l1) begin
            addr_d          = pte_addr(pte_ppn, vpn_q[IDX_W-1:0]);
            mem_req_valid_d = 1'b1;
            state_d         = L0_REQ;
          end else begin
            // Pointer PTE at the last level: nothing left to walk.
            fault_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        if (ptw_resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vpn_q            <= '0;
      req_ready_q      <= 1'b1;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      addr_q           <= '0;
      resp_valid_q     <= 1'b0;
      pte_q            <= '0;
      level_q          <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      vpn_q            <= vpn_d;
      req_ready_q      <= req_ready_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_resp_ready_q <= mem_resp_ready_d;
      addr_q           <= addr_d;
      resp_valid_q     <= resp_valid_d;
      pte_q            <= pte_d;
      level_q          <= level_d;
      fault_q          <= fault_d;
    end
  end

  assign ptw_req_ready_o  = req_ready_q;
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_req_addr_o   = addr_q;
  assign mem_resp_ready_o = mem_resp_ready_q;
  assign ptw_resp_valid_o = resp_valid_q;
  assign ptw_resp_pte_o   = pte_q;
  assign ptw_resp_level_o = level_q;
  assign ptw_resp_fault_o = fault_q;

endmodule
